// File: rtl/sort_host_if.sv
// Producer/consumer stream bundle around sort_host: batch words in, sorted words out.
interface sort_host_if #(parameter int DW = 16);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sort_host.sv
// Host-side sequencer for the insertion-sort engine: streams a batch in, drives the
// clear/push/sort/pop command levels, then streams the popped (non-increasing) words out.
//
// state     | meaning
// ST_IDLE   | waiting for the first beat of a batch
// ST_CLEAR  | clear command in flight
// ST_ACCEPT | offering s_ready for the next word
// ST_PUSH   | push command in flight, din_o held
// ST_DRAIN  | engine full, discarding beats up to s_last
// ST_SORT   | sort command in flight
// ST_POP    | empty check, then pop command in flight
// ST_OUT    | presenting a popped word until m_ready
// ST_DONE   | one-cycle batch epilogue
module sort_host #(
  parameter int PULSE_HI = 3,  // >= 2 so the engine's synchroniser sees a rising edge
  parameter int GUARD    = 2,  // >= 1
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  sort_host_if.slave    bus,
  output logic          push,
  output logic          pop,
  output logic          clear,
  output logic          sort,
  output logic [DW-1:0] din_o,
  input  logic [DW-1:0] dout_i,
  input  logic          full_i,
  input  logic          empty_i,
  input  logic          idle_i,
  output logic          ovf,
  output logic          err_order,
  output logic          busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLEAR, ST_ACCEPT, ST_PUSH, ST_DRAIN, ST_SORT, ST_POP, ST_OUT, ST_DONE
  } state_t;

  typedef enum logic [1:0] {CPH_CHK, CPH_HI, CPH_LO, CPH_WAIT} cph_t;

  localparam int TW = 8;
  localparam logic [TW-1:0] HI_LOAD = TW'(PULSE_HI - 1);
  localparam logic [TW-1:0] LO_LOAD = TW'(GUARD - 1);

  state_t        state_q, state_d;
  cph_t          cph_q, cph_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] din_q, din_d, prev_q, prev_d, m_data_q, m_data_d;
  logic          last_seen_q, last_seen_d, first_out_q, first_out_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic [7:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic          s_rdy, s_hs, m_vld, m_hs;
  logic          cmd_done, cmd_start, cmd_park;

  // Handshakes are masked by enable so a frozen host never loses or duplicates a beat.
  assign s_rdy = enable && (state_q == ST_ACCEPT || state_q == ST_DRAIN);
  assign s_hs  = bus.s_valid && s_rdy;
  assign m_vld = enable && m_valid_q;
  assign m_hs  = m_vld && bus.m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cph_q       <= CPH_CHK;
      tmr_q       <= '0;
      din_q       <= '0;
      prev_q      <= '0;
      m_data_q    <= '0;
      last_seen_q <= 1'b0;
      first_out_q <= 1'b1;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
    end else if (enable) begin
      state_q     <= state_d;
      cph_q       <= cph_d;
      tmr_q       <= tmr_d;
      din_q       <= din_d;
      prev_q      <= prev_d;
      m_data_q    <= m_data_d;
      last_seen_q <= last_seen_d;
      first_out_q <= first_out_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cph_d       = cph_q;
    tmr_d       = tmr_q;
    din_d       = din_q;
    prev_d      = prev_q;
    m_data_d    = m_data_q;
    last_seen_d = last_seen_q;
    first_out_d = first_out_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    cmd_done    = 1'b0;
    cmd_start   = 1'b0;
    cmd_park    = 1'b0;

    // Shared command subroutine: high pulse, low guard, then wait for the engine.
    case (cph_q)
      CPH_HI: begin
        if (tmr_q == '0) begin
          cph_d = CPH_LO;
          tmr_d = LO_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      CPH_LO: begin
        if (tmr_q == '0) cph_d = CPH_WAIT;
        else             tmr_d = tmr_q - TW'(1);
      end
      CPH_WAIT: cmd_done = idle_i;
      default: ;
    endcase

    if (s_hs && in_cnt_q != 8'hFF)  in_cnt_d  = in_cnt_q + 8'd1;
    if (m_hs && out_cnt_q != 8'hFF) out_cnt_d = out_cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          first_out_d = 1'b1;
          last_seen_d = 1'b0;
          cmd_start   = 1'b1;
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cmd_done) begin
          cmd_park = 1'b1;
          state_d  = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (full_i) begin
          ovf_d = 1'b1;
          if (s_hs && bus.s_last) begin
            cmd_start = 1'b1;
            state_d   = ST_SORT;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (s_hs) begin
          din_d       = bus.s_data;
          last_seen_d = bus.s_last;
          cmd_start   = 1'b1;
          state_d     = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (cmd_done) begin
          if (last_seen_q) begin
            cmd_start = 1'b1;
            state_d   = ST_SORT;
          end else begin
            cmd_park = 1'b1;
            state_d  = ST_ACCEPT;
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs && bus.s_last) begin
          cmd_start = 1'b1;
          state_d   = ST_SORT;
        end
      end
      ST_SORT: begin
        if (cmd_done) begin
          cmd_park = 1'b1;
          state_d  = ST_POP;
        end
      end
      ST_POP: begin
        if (cph_q == CPH_CHK) begin
          if (empty_i) state_d = ST_DONE;
          else         cmd_start = 1'b1;
        end else if (cmd_done) begin
          m_data_d    = dout_i;
          m_last_d    = empty_i;
          m_valid_d   = 1'b1;
          if (!first_out_q && dout_i > prev_q) err_d = 1'b1;
          prev_d      = dout_i;
          first_out_d = 1'b0;
          cmd_park    = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_hs) begin
          m_valid_d = 1'b0;
          state_d   = m_last_q ? ST_DONE : ST_POP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cmd_start) begin
      cph_d = CPH_HI;
      tmr_d = HI_LOAD;
    end else if (cmd_park) begin
      cph_d = CPH_CHK;
    end
  end

  assign clear = (state_q == ST_CLEAR) && (cph_q == CPH_HI);
  assign push  = (state_q == ST_PUSH)  && (cph_q == CPH_HI);
  assign sort  = (state_q == ST_SORT)  && (cph_q == CPH_HI);
  assign pop   = (state_q == ST_POP)   && (cph_q == CPH_HI);

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = m_vld;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign din_o       = din_q;
  assign ovf         = ovf_q;
  assign err_order   = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sort_host.sv
// Bench for sort_host: behavioural sort engine, randomized batches, queue scoreboard.
module tb_sort_host;
  localparam int PULSE_HI = 3;
  localparam int GUARD    = 2;
  localparam int DW       = 16;
  localparam byte K_CLR = 8'h43, K_PSH = 8'h50, K_SRT = 8'h53, K_POP = 8'h4F;

  typedef struct {logic [DW-1:0] d; bit last;} beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic cmd_push, cmd_pop, cmd_clear, cmd_sort;
  logic [DW-1:0] din_o;
  logic [DW-1:0] dout_i = '0;
  logic full_i = 1'b0, empty_i = 1'b1, idle_i = 1'b1;
  logic ovf, err_order, busy;

  sort_host_if #(.DW(DW)) bus ();

  sort_host #(.PULSE_HI(PULSE_HI), .GUARD(GUARD), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .enable(en), .bus(bus),
    .push(cmd_push), .pop(cmd_pop), .clear(cmd_clear), .sort(cmd_sort),
    .din_o(din_o), .dout_i(dout_i), .full_i(full_i), .empty_i(empty_i), .idle_i(idle_i),
    .ovf(ovf), .err_order(err_order), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  byte cmd_log[$];
  logic [DW-1:0] eng_q[$];
  logic [DW-1:0] bw[$];
  int eng_cap = 255;
  bit eng_nosort = 0;
  int ready_pct = 100;
  int gap_max = 0;
  bit stall_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural engine: acts on each command rising edge, then stays non-idle a while.
  initial begin
    logic [3:0] pins, pins_p;
    int wid[4];
    int busy_cnt;
    bit act;
    pins_p = '0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) wid[i] = 0;
    forever begin
      @(negedge clk);
      act = 0;
      if (busy_cnt > 0) busy_cnt--;
      pins = {cmd_clear, cmd_push, cmd_sort, cmd_pop};
      if (pins != 4'b0) chk("one_cmd_pin", 32'($countones(pins)), 1);
      for (int i = 0; i < 4; i++) begin
        if (!rstn) wid[i] = 0;
        else if (pins[i]) wid[i]++;
        else if (wid[i] != 0) begin
          chk("pulse_width", wid[i], PULSE_HI);
          wid[i] = 0;
        end
      end
      if (rstn) begin
        if (pins[3] && !pins_p[3]) begin
          eng_q.delete(); cmd_log.push_back(K_CLR); act = 1;
        end
        if (pins[2] && !pins_p[2]) begin
          chk("push_not_full", eng_q.size() < eng_cap, 1);
          if (eng_q.size() < eng_cap) eng_q.push_back(din_o);
          cmd_log.push_back(K_PSH); act = 1;
        end
        if (pins[1] && !pins_p[1]) begin
          if (!eng_nosort) eng_q.rsort();
          cmd_log.push_back(K_SRT); act = 1;
        end
        if (pins[0] && !pins_p[0]) begin
          chk("pop_not_empty", eng_q.size() > 0, 1);
          chk("pop_without_mvalid", bus.m_valid, 0);
          if (eng_q.size() > 0) dout_i = eng_q.pop_front();
          cmd_log.push_back(K_POP); act = 1;
        end
      end
      pins_p = pins;
      if (act) busy_cnt = $urandom_range(1, 8);
      idle_i  = (busy_cnt == 0);
      full_i  = (eng_q.size() >= eng_cap);
      empty_i = (eng_q.size() == 0);
    end
  end

  // Consumer and scoreboard monitor.
  initial begin
    beat_t e;
    logic [DW-1:0] d0;
    bit ok;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_req && bus.m_valid) begin
        stall_req = 0;
        bus.m_ready = 1'b0;
        d0 = bus.m_data;
        ok = 1;
        repeat (20) begin
          @(negedge clk);
          if (!bus.m_valid || bus.m_data !== d0 || cmd_pop) ok = 0;
        end
        chk("out_hold_stable", ok, 1);
      end
      bus.m_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (bus.m_valid) chk("sready_with_mvalid", bus.s_ready, 0);
      if (bus.m_valid && bus.m_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", bus.m_data, e.d);
          chk("m_last", bus.m_last, e.last);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic put(input logic [DW-1:0] d, input bit last, output bit ok);
    int c = 0;
    ok = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
    while (c < 2000) begin
      #1;
      if (bus.s_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
      c++;
    end
    bus.s_valid = 1'b0;
    if (!ok) chk("s_handshake", ok, 1);
  endtask

  task automatic send_batch();
    int n, kept, c;
    logic [DW-1:0] k[$];
    byte es[$];
    bit e_err, ok, seq_ok;
    n = bw.size();
    kept = (n > eng_cap) ? eng_cap : n;
    for (int i = 0; i < kept; i++) k.push_back(bw[i]);
    if (!eng_nosort) k.rsort();
    e_err = 0;
    for (int i = 1; i < kept; i++) if (k[i] > k[i-1]) e_err = 1;
    for (int i = 0; i < kept; i++) exp_q.push_back('{k[i], (i == kept - 1)});
    es.push_back(K_CLR);
    for (int i = 0; i < kept; i++) es.push_back(K_PSH);
    es.push_back(K_SRT);
    for (int i = 0; i < kept; i++) es.push_back(K_POP);
    cmd_log.delete();
    for (int i = 0; i < n; i++) begin
      put(bw[i], (i == n - 1), ok);
      if (i == 0) chk("flags_cleared", {30'b0, ovf, err_order}, 0);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    c = 0;
    while (busy && c < 30000) begin
      @(negedge clk);
      c++;
    end
    chk("batch_done", busy, 0);
    chk("all_beats_out", exp_q.size(), 0);
    chk("ovf", ovf, (n > eng_cap));
    chk("err_order", err_order, e_err);
    seq_ok = (cmd_log.size() == es.size());
    if (seq_ok) for (int i = 0; i < es.size(); i++) if (cmd_log[i] != es[i]) seq_ok = 0;
    chk("cmd_seq_len", cmd_log.size(), es.size());
    chk("cmd_seq", seq_ok, 1);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_cmd_pins", {cmd_clear, cmd_push, cmd_sort, cmd_pop}, 0);
    chk("rst_din_o", din_o, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err_order", err_order, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    #3;
    check_reset_values();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    bw = '{16'd5, 16'd3, 16'd9, 16'd1};
    send_batch();

    bw = '{16'h00AA};
    send_batch();

    stall_req = 1;
    bw = '{16'h1234, 16'h0042, 16'hBEEF};
    send_batch();
    chk("stall_exercised", stall_req, 0);

    ready_pct = 60;
    gap_max = 2;
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 12);
      bw.delete();
      for (int i = 0; i < n; i++)
        bw.push_back((b % 2) ? DW'($urandom_range(0, 7)) : DW'($urandom));
      send_batch();
    end

    ready_pct = 100;
    gap_max = 0;
    bw.delete();
    for (int i = 0; i < 300; i++) bw.push_back(DW'($urandom));
    send_batch();

    eng_nosort = 1;
    bw = '{16'd4, 16'd7};
    send_batch();
    eng_nosort = 0;
    repeat (10) @(negedge clk);
    chk("err_order_sticky", err_order, 1);
    bw = '{16'd20, 16'd10, 16'd30};
    send_batch();

    // Abort a batch with a push pulse in flight.
    put(16'h0777, 1'b0, ok);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (cmd_push) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("push_seen_before_reset", seen, 1);
    #2 rstn = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bw = '{16'd8, 16'd2, 16'd6};
    send_batch();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
